// File: rtl/stream_pkg.sv
// Shared types for the stream id demultiplexer: routing FSM states and output buffer depth.
// No logic; imported by the top and by the per-output buffer.
package stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } route_state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/stream_id_demux_if.sv
// Input stream plus per-output streams of the id demux; slave is the demux side, master the source/sink side.
// Latency and backpressure are defined by the module attached to the slave modport.
interface stream_id_demux_if #(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 2,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT)
) ();

    logic [T_DATA_WIDTH-1:0] s_data_i;
    logic [T_ID___WIDTH-1:0] s_id_i;
    logic                    s_last_i;
    logic                    s_valid_i;
    logic                    s_ready_o;

    logic [T_DATA_WIDTH-1:0] m_data_o [S_DATA_COUNT];
    logic [S_DATA_COUNT-1:0] m_last_o;
    logic [S_DATA_COUNT-1:0] m_valid_o;
    logic [S_DATA_COUNT-1:0] m_ready_i;

    logic                    err_o;

    modport slave (
        input  s_data_i, s_id_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_last_o, m_valid_o, err_o
    );

    modport master (
        output s_data_i, s_id_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_last_o, m_valid_o, err_o
    );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO for one demux output; 1-cycle push-to-head latency, full at 2 entries.
// o_full depends only on the stored count, never on i_rdy; push and pop in one cycle keep the count.
module stream_skid_buf
    import stream_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [T_DATA_WIDTH-1:0] i_dat,
    input  logic                    i_last,
    output logic                    o_full,
    output logic                    o_vld,
    input  logic                    i_rdy,
    output logic [T_DATA_WIDTH-1:0] o_dat,
    output logic                    o_last
);

    logic [T_DATA_WIDTH-1:0] r_dat [SKID_DEPTH];
    logic [SKID_DEPTH-1:0]   r_last;
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_cnt;
    logic                    w_push;
    logic                    w_pop;

    assign o_full = (r_cnt == 2'(SKID_DEPTH));
    assign o_vld  = (r_cnt != 2'd0);
    assign o_dat  = r_dat[r_rd_ptr];
    assign o_last = r_last[r_rd_ptr];
    assign w_push = i_push && !o_full;
    assign w_pop  = o_vld && i_rdy;

    // Storage is cleared too so the outputs read zero throughout reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dat[0] <= '0;
            r_dat[1] <= '0;
            r_last   <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_dat[r_wr_ptr]  <= i_dat;
                r_last[r_wr_ptr] <= i_last;
                r_wr_ptr         <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/stream_id_demux.sv
// Routes whole packets to the output selected by the first beat's id; 1-cycle latency via per-output 2-entry FIFOs.
// s_ready_o follows only the selected output's fill level; packets to an out-of-range id are swallowed with an err_o pulse.
module stream_id_demux
    import stream_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 2,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT)
) (
    input  logic             clk,
    input  logic             rst,
    stream_id_demux_if.slave bus
);

    route_state_t            r_state;
    route_state_t            w_state_nxt;
    logic [T_ID___WIDTH-1:0] r_dest;
    logic [T_ID___WIDTH-1:0] w_dest_nxt;
    logic [T_ID___WIDTH-1:0] w_dest;
    logic [S_DATA_COUNT-1:0] w_sel;
    logic [S_DATA_COUNT-1:0] w_full;
    logic [S_DATA_COUNT-1:0] w_push;
    logic                    w_dest_ok;
    logic                    w_fire;

    assign w_dest = (r_state == PKT) ? r_dest : bus.s_id_i;

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < S_DATA_COUNT; k++) begin
            w_sel[k] = (int'(w_dest) == k);
        end
    end

    // No output selected means the id is out of range: accept and drop.
    assign w_dest_ok     = |w_sel;
    assign bus.s_ready_o = !w_dest_ok || (|(w_sel & ~w_full));
    assign w_fire        = bus.s_valid_i && bus.s_ready_o;
    assign w_push        = w_fire ? w_sel : '0;
    assign bus.err_o     = w_fire && !w_dest_ok && (r_state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_dest  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dest  <= w_dest_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dest_nxt  = r_dest;
        if (w_fire) begin
            if ((r_state == IDLE) && !bus.s_last_i) begin
                w_state_nxt = PKT;
                w_dest_nxt  = bus.s_id_i;
            end else if ((r_state == PKT) && bus.s_last_i) begin
                w_state_nxt = IDLE;
            end
        end
    end

    for (genvar k = 0; k < S_DATA_COUNT; k++) begin : g_out
        stream_skid_buf #(
            .T_DATA_WIDTH (T_DATA_WIDTH)
        ) u_buf (
            .clk    (clk),
            .rst    (rst),
            .i_push (w_push[k]),
            .i_dat  (bus.s_data_i),
            .i_last (bus.s_last_i),
            .o_full (w_full[k]),
            .o_vld  (bus.m_valid_o[k]),
            .i_rdy  (bus.m_ready_i[k]),
            .o_dat  (bus.m_data_o[k]),
            .o_last (bus.m_last_o[k])
        );
    end

endmodule

// File: tb/tb_stream_id_demux.sv
// Directed bench for stream_id_demux: a 2-output instance and a 3-output instance with a 2-bit id.
module tb_stream_id_demux;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    stream_id_demux_if #(.T_DATA_WIDTH(8), .S_DATA_COUNT(2), .T_ID___WIDTH(1)) ifa ();
    stream_id_demux_if #(.T_DATA_WIDTH(8), .S_DATA_COUNT(3), .T_ID___WIDTH(2)) ifb ();

    stream_id_demux #(.T_DATA_WIDTH(8), .S_DATA_COUNT(2), .T_ID___WIDTH(1)) u_dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave)
    );
    stream_id_demux #(.T_DATA_WIDTH(8), .S_DATA_COUNT(3), .T_ID___WIDTH(2)) u_dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave)
    );

    task automatic test_reset;
        rst = 1'b1;
        #3;
        n_checks++;
        if (ifa.m_valid_o !== 2'b00 || ifa.m_last_o !== 2'b00 || ifa.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a_ctrl: got vld=%b last=%b err=%b, want 00 00 0", ifa.m_valid_o, ifa.m_last_o, ifa.err_o);
        end
        n_checks++;
        if (ifa.m_data_o[0] !== 8'h00 || ifa.m_data_o[1] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_a_data: got %h %h, want 00 00", ifa.m_data_o[0], ifa.m_data_o[1]);
        end
        n_checks++;
        if (ifb.m_valid_o !== 3'b000 || ifb.m_last_o !== 3'b000 || ifb.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b_ctrl: got vld=%b last=%b err=%b, want 000 000 0", ifb.m_valid_o, ifb.m_last_o, ifb.err_o);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifa.s_ready_o !== 1'b1 || ifa.m_valid_o !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b vld=%b, want 1 00", ifa.s_ready_o, ifa.m_valid_o);
        end
        @(posedge clk);
        #1;
    endtask

    // 3-beat packet to id 1; output 1 shows each beat one cycle after acceptance.
    task automatic test_route;
        logic [7:0] d [3];
        d = '{8'h11, 8'h22, 8'h33};
        ifa.m_ready_i = 2'b11;
        for (int i = 0; i <= 4; i++) begin
            ifa.s_valid_i = (i < 3);
            if (i < 3) begin
                ifa.s_data_i = d[i];
                ifa.s_id_i   = 1'b1;
                ifa.s_last_i = (i == 2);
            end
            @(negedge clk);
            if (i < 3) begin
                n_checks++;
                if (ifa.s_ready_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL route_rdy cyc%0d: got %b, want 1", i, ifa.s_ready_o);
                end
            end
            n_checks++;
            if (ifa.m_valid_o[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL route_out0_idle cyc%0d: got vld0=%b, want 0", i, ifa.m_valid_o[0]);
            end
            n_checks++;
            if (i >= 1 && i <= 3) begin
                if (ifa.m_valid_o[1] !== 1'b1 || ifa.m_data_o[1] !== d[i-1] || ifa.m_last_o[1] !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL route_out1 cyc%0d: got vld=%b dat=%h last=%b, want 1 %h %b",
                             i, ifa.m_valid_o[1], ifa.m_data_o[1], ifa.m_last_o[1], d[i-1], (i == 3));
                end
            end else if (ifa.m_valid_o[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL route_out1_idle cyc%0d: got vld1=%b, want 0", i, ifa.m_valid_o[1]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // id changes mid-packet must not redirect the packet.
    task automatic test_id_switch;
        logic [7:0] d [3];
        logic       id [3];
        d  = '{8'h44, 8'h55, 8'h66};
        id = '{1'b0, 1'b1, 1'b1};
        ifa.m_ready_i = 2'b11;
        for (int i = 0; i <= 4; i++) begin
            ifa.s_valid_i = (i < 3);
            if (i < 3) begin
                ifa.s_data_i = d[i];
                ifa.s_id_i   = id[i];
                ifa.s_last_i = (i == 2);
            end
            @(negedge clk);
            n_checks++;
            if (i >= 1 && i <= 3) begin
                if (ifa.m_valid_o !== 2'b01 || ifa.m_data_o[0] !== d[i-1] || ifa.m_last_o[0] !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL idsw_out0 cyc%0d: got vld=%b dat=%h last=%b, want 01 %h %b",
                             i, ifa.m_valid_o, ifa.m_data_o[0], ifa.m_last_o[0], d[i-1], (i == 3));
                end
            end else if (ifa.m_valid_o !== 2'b00) begin
                n_fail++;
                $display("FAIL idsw_idle cyc%0d: got vld=%b, want 00", i, ifa.m_valid_o);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Output 0 stalled: two beats buffered, s_ready_o drops, head held until release.
    task automatic test_backpressure;
        logic [7:0] src [4];
        logic [7:0] ed  [11];
        logic       ev  [11];
        logic       el  [11];
        logic       er  [11];
        logic       fire;
        int         idx;
        idx = 0;
        src = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        ev  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ed  = '{8'h00, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00};
        el  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        er  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 11; c++) begin
            ifa.m_ready_i = {1'b1, (c >= 6)};
            ifa.s_valid_i = (idx < 4);
            if (idx < 4) begin
                ifa.s_data_i = src[idx];
                ifa.s_id_i   = 1'b0;
                ifa.s_last_i = (idx == 3);
            end
            @(negedge clk);
            if (ifa.s_valid_i) begin
                n_checks++;
                if (ifa.s_ready_o !== er[c]) begin
                    n_fail++;
                    $display("FAIL bp_rdy cyc%0d: got %b, want %b", c, ifa.s_ready_o, er[c]);
                end
            end
            n_checks++;
            if (ifa.m_valid_o !== {1'b0, ev[c]}) begin
                n_fail++;
                $display("FAIL bp_vld cyc%0d: got %b, want %b", c, ifa.m_valid_o, {1'b0, ev[c]});
            end
            if (ev[c]) begin
                n_checks++;
                if (ifa.m_data_o[0] !== ed[c] || ifa.m_last_o[0] !== el[c]) begin
                    n_fail++;
                    $display("FAIL bp_head cyc%0d: got dat=%h last=%b, want %h %b", c, ifa.m_data_o[0], ifa.m_last_o[0], ed[c], el[c]);
                end
            end
            fire = ifa.s_valid_i && ifa.s_ready_o;
            @(posedge clk);
            #1;
            if (fire) idx++;
        end
        ifa.s_valid_i = 1'b0;
    endtask

    // Packet to id 3 on a 3-output demux is swallowed; later ids 0 on its beats stay dropped.
    task automatic test_bad_id;
        logic [7:0] d    [4];
        logic [1:0] id   [4];
        logic       ee   [6];
        logic [2:0] evld [6];
        int         n_err;
        n_err = 0;
        d    = '{8'hB0, 8'hB1, 8'hB2, 8'hC5};
        id   = '{2'd3, 2'd0, 2'd0, 2'd2};
        ee   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        evld = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000};
        ifb.m_ready_i = 3'b111;
        for (int c = 0; c < 6; c++) begin
            ifb.s_valid_i = (c < 4);
            if (c < 4) begin
                ifb.s_data_i = d[c];
                ifb.s_id_i   = id[c];
                ifb.s_last_i = (c >= 2);
            end
            @(negedge clk);
            if (c < 4) begin
                n_checks++;
                if (ifb.s_ready_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bad_rdy cyc%0d: got %b, want 1", c, ifb.s_ready_o);
                end
            end
            if (ifb.err_o === 1'b1) n_err++;
            n_checks++;
            if (ifb.err_o !== ee[c] || ifb.m_valid_o !== evld[c]) begin
                n_fail++;
                $display("FAIL bad_out cyc%0d: got err=%b vld=%b, want %b %b", c, ifb.err_o, ifb.m_valid_o, ee[c], evld[c]);
            end
            if (c == 4) begin
                n_checks++;
                if (ifb.m_data_o[2] !== 8'hC5 || ifb.m_last_o[2] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bad_next_pkt: got dat=%h last=%b, want c5 1", ifb.m_data_o[2], ifb.m_last_o[2]);
                end
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (n_err != 1) begin
            n_fail++;
            $display("FAIL bad_err_pulses: got %0d, want 1", n_err);
        end
    endtask

    task automatic test_reset_mid;
        ifa.m_ready_i = 2'b00;
        ifa.s_valid_i = 1'b1;
        ifa.s_data_i  = 8'h71;
        ifa.s_id_i    = 1'b1;
        ifa.s_last_i  = 1'b0;
        @(posedge clk);
        #1 ifa.s_valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifa.m_valid_o !== 2'b10 || ifa.m_data_o[1] !== 8'h71) begin
            n_fail++;
            $display("FAIL rmid_before: got vld=%b dat=%h, want 10 71", ifa.m_valid_o, ifa.m_data_o[1]);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (ifa.m_valid_o !== 2'b00 || ifa.m_data_o[1] !== 8'h00 || ifa.m_last_o !== 2'b00) begin
            n_fail++;
            $display("FAIL rmid_async: got vld=%b dat=%h last=%b, want 00 00 00", ifa.m_valid_o, ifa.m_data_o[1], ifa.m_last_o);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        ifa.m_ready_i = 2'b11;
        ifa.s_valid_i = 1'b1;
        ifa.s_data_i  = 8'h81;
        ifa.s_id_i    = 1'b0;
        ifa.s_last_i  = 1'b1;
        @(posedge clk);
        #1 ifa.s_valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifa.m_valid_o !== 2'b01 || ifa.m_data_o[0] !== 8'h81 || ifa.m_last_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_after: got vld=%b dat=%h last=%b, want 01 81 1", ifa.m_valid_o, ifa.m_data_o[0], ifa.m_last_o[0]);
        end
        @(posedge clk);
        #1;
    endtask

    // Alternating single-beat packets against random per-output ready; scoreboard per output.
    task automatic test_back_to_back;
        logic [7:0] q0 [$];
        logic [7:0] q1 [$];
        logic [7:0] exp_d;
        logic       fire;
        int         sent, recv, cyc;
        sent = 0;
        recv = 0;
        cyc  = 0;
        while ((sent < 40 || q0.size() != 0 || q1.size() != 0) && cyc < 600) begin
            ifa.m_ready_i = (sent < 40) ? 2'($urandom_range(0, 3)) : 2'b11;
            ifa.s_valid_i = (sent < 40);
            ifa.s_id_i    = sent[0];
            ifa.s_data_i  = 8'(8'h30 + sent);
            ifa.s_last_i  = 1'b1;
            @(negedge clk);
            if (ifa.m_valid_o[0] && ifa.m_ready_i[0]) begin
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_out0_extra: got dat=%h, want no beat", ifa.m_data_o[0]);
                end else begin
                    exp_d = q0.pop_front();
                    recv++;
                    if (ifa.m_data_o[0] !== exp_d || ifa.m_last_o[0] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL b2b_out0: got dat=%h last=%b, want %h 1", ifa.m_data_o[0], ifa.m_last_o[0], exp_d);
                    end
                end
            end
            if (ifa.m_valid_o[1] && ifa.m_ready_i[1]) begin
                n_checks++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_out1_extra: got dat=%h, want no beat", ifa.m_data_o[1]);
                end else begin
                    exp_d = q1.pop_front();
                    recv++;
                    if (ifa.m_data_o[1] !== exp_d || ifa.m_last_o[1] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL b2b_out1: got dat=%h last=%b, want %h 1", ifa.m_data_o[1], ifa.m_last_o[1], exp_d);
                    end
                end
            end
            fire = ifa.s_valid_i && ifa.s_ready_o;
            if (fire) begin
                if (ifa.s_id_i == 1'b0) q0.push_back(ifa.s_data_i);
                else                    q1.push_back(ifa.s_data_i);
            end
            @(posedge clk);
            #1;
            if (fire) sent++;
            cyc++;
        end
        ifa.s_valid_i = 1'b0;
        n_checks++;
        if (recv != 40 || sent != 40) begin
            n_fail++;
            $display("FAIL b2b_count: got sent=%0d recv=%0d, want 40 40", sent, recv);
        end
    endtask

    initial begin
        rst           = 1'b1;
        ifa.s_valid_i = 1'b0;
        ifa.s_data_i  = '0;
        ifa.s_id_i    = '0;
        ifa.s_last_i  = 1'b0;
        ifa.m_ready_i = '0;
        ifb.s_valid_i = 1'b0;
        ifb.s_data_i  = '0;
        ifb.s_id_i    = '0;
        ifb.s_last_i  = 1'b0;
        ifb.m_ready_i = '0;
        test_reset();
        test_route();
        test_id_switch();
        test_backpressure();
        test_bad_id();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, want completion");
        $fatal(1, "watchdog");
    end

endmodule
